// File: rtl/dp_pkg.sv
// Shared types and encodings for the parametrised datapath: op fields, FSM states
// and the captured-operation record.
package dp_pkg;

  localparam int unsigned SHIFT_BITS = 2;
  localparam int unsigned ALUOP_BITS = 2;
  localparam int unsigned VSEL_BITS  = 2;

  typedef enum logic [ALUOP_BITS-1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [SHIFT_BITS-1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [VSEL_BITS-1:0] {
    VSEL_C     = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM8  = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_DONE = 3'd5
  } dp_state_e;

  // Width-independent control fields latched at start; operands are held separately.
  typedef struct packed {
    shift_e  shift;
    alu_op_e aluop;
    logic    asel;
    logic    bsel;
    vsel_e   vsel;
    logic    wb_en;
    logic    flags_en;
  } dp_op_t;

  localparam dp_op_t DP_OP_CLEAR = '0;

endpackage

// File: rtl/regfile_p.sv
// NREG x W register file: combinational dual read, synchronous single write,
// asynchronous active-low clear.
module regfile_p
  import dp_pkg::*;
#(
  parameter  int unsigned W    = 16,
  parameter  int unsigned NREG = 8,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [RW-1:0] raddr_a,
  input  logic [RW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/param_datapath.sv
// Self-sequenced W-bit datapath: register file, A/B/C pipeline, 1-bit shifter,
// ALU and Z/N/V status, one operation per start/done handshake.
module param_datapath
  import dp_pkg::*;
#(
  parameter  int unsigned W    = 16,
  parameter  int unsigned NREG = 8,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  input  logic [RW-1:0] rd,
  input  logic [1:0]    shift,
  input  logic [1:0]    aluop,
  input  logic          asel,
  input  logic          bsel,
  input  logic [1:0]    vsel,
  input  logic          wb_en,
  input  logic          flags_en,
  input  logic [W-1:0]  sximm8,
  input  logic [W-1:0]  sximm5,
  input  logic [W-1:0]  pc,
  input  logic [W-1:0]  mdata,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  datapath_out,
  output logic          Z_out,
  output logic          N_out,
  output logic          V_out
);

  dp_state_e     state_q, state_d;
  dp_op_t        op_q, op_d;
  logic [RW-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic [W-1:0]  imm8_q, imm8_d, imm5_q, imm5_d, pc_q, pc_d, mdata_q, mdata_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic          z_q, z_d, n_q, n_d, v_q, v_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [W-1:0]  rf_a, rf_b, wb_data;
  logic [W-1:0]  b_shift, ain, bin, alu_out;
  logic          alu_v, rf_we;

  regfile_p #(.W(W), .NREG(NREG)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (wb_data),
    .raddr_a (rn_q),
    .raddr_b (rm_q),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  always_comb begin
    case (op_q.shift)
      SH_NONE: b_shift = b_q;
      SH_LSL1: b_shift = {b_q[W-2:0], 1'b0};
      SH_LSR1: b_shift = {1'b0, b_q[W-1:1]};
      SH_ASR1: b_shift = {b_q[W-1], b_q[W-1:1]};
      default: b_shift = b_q;
    endcase
  end

  always_comb begin
    ain     = op_q.asel ? '0 : a_q;
    bin     = op_q.bsel ? imm5_q : b_shift;
    alu_out = '0;
    alu_v   = 1'b0;
    case (op_q.aluop)
      ALU_ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[W-1] == bin[W-1]) && (alu_out[W-1] != ain[W-1]);
      end
      ALU_SUB: begin
        alu_out = ain - bin;
        alu_v   = (ain[W-1] != bin[W-1]) && (alu_out[W-1] != ain[W-1]);
      end
      ALU_AND:  alu_out = ain & bin;
      ALU_NOTB: alu_out = ~bin;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    case (op_q.vsel)
      VSEL_C:     wb_data = c_q;
      VSEL_PC:    wb_data = pc_q;
      VSEL_IMM8:  wb_data = imm8_q;
      VSEL_MDATA: wb_data = mdata_q;
      default:    wb_data = c_q;
    endcase
  end

  assign rf_we = (state_q == ST_WB) && op_q.wb_en;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    imm8_d  = imm8_q;
    imm5_d  = imm5_q;
    pc_d    = pc_q;
    mdata_d = mdata_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = '{shift: shift_e'(shift), aluop: alu_op_e'(aluop), asel: asel,
                      bsel: bsel, vsel: vsel_e'(vsel), wb_en: wb_en, flags_en: flags_en};
          rn_d    = rn;
          rm_d    = rm;
          rd_d    = rd;
          imm8_d  = sximm8;
          imm5_d  = sximm5;
          pc_d    = pc;
          mdata_d = mdata;
          state_d = (vsel_e'(vsel) == VSEL_C) ? ST_RD_A : ST_WB;
        end
      end
      ST_RD_A: begin
        a_d     = rf_a;
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        b_d     = rf_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        c_d = alu_out;
        if (op_q.flags_en) begin
          z_d = (alu_out == '0);
          n_d = alu_out[W-1];
          v_d = alu_v;
        end
        state_d = ST_WB;
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered from the next state so they align with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= DP_OP_CLEAR;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      imm8_q  <= '0;
      imm5_q  <= '0;
      pc_q    <= '0;
      mdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      imm8_q  <= imm8_d;
      imm5_q  <= imm5_d;
      pc_q    <= pc_d;
      mdata_q <= mdata_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;

endmodule
